// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage.
// Holds the fetch PC and drives a synchronous-read instruction SRAM (one-cycle
// read latency). Each returned word is stored with its PC in a small in-order
// buffer. The buffer head goes to ID through a valid/allowin handshake, and a
// redirect flushes the stage.
// Optional feature macro: IF_ADEL_CHECK_EN. When it is defined, a misaligned
// fetch PC produces an address-error entry instead of an SRAM read.
`timescale 1ns/1ps

module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'hbfc00000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_sram_en,
   output logic [31:0] inst_sram_addr,
   input  logic [31:0] inst_sram_rdata,
   input  logic        id_allowin,
   output logic        if_to_id_valid,
   output logic [31:0] if_to_id_pc,
   output logic [31:0] if_to_id_inst
`ifdef IF_ADEL_CHECK_EN
   ,
   output logic        if_to_id_adel
`endif
);

   localparam int IDX_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = $clog2(BUF_DEPTH + 1);

   // Fetch PC and the single outstanding SRAM read
   logic [31:0]      fpc;
   logic             inflight;
   logic [31:0]      inflight_pc;

   // In-order instruction buffer (circular)
   logic [31:0]      fifo_pc   [BUF_DEPTH];
   logic [31:0]      fifo_inst [BUF_DEPTH];
   logic [IDX_W-1:0] rd_ptr;
   logic [IDX_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;

   // Handshake and issue control
   logic             deq;
   logic             push;
   logic             slot_ok;
   logic             issue;
   logic [CNT_W:0]   occ;
   logic [31:0]      push_inst;

`ifdef IF_ADEL_CHECK_EN
   logic             misalign;
   logic             halted;
   logic             inflight_adel;
   logic             fifo_adel [BUF_DEPTH];
`endif

   function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
      return (p == IDX_W'(BUF_DEPTH - 1)) ? '0 : p + IDX_W'(1);
   endfunction

   // Dequeue, occupancy-based issue decision and SRAM request
   always_comb begin
      // NOTE: each signal written here gets a value on every path. Without that, a latch is inferred.
      deq     = if_to_id_valid & id_allowin & ~redirect_valid;
      occ     = {1'b0, count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, deq};
      slot_ok = resetn & ~redirect_valid & (occ < (CNT_W + 1)'(BUF_DEPTH));
      push    = inflight & ~redirect_valid;
`ifdef IF_ADEL_CHECK_EN
      misalign     = (fpc[1:0] != 2'b00);
      issue        = slot_ok & ~halted;
      inst_sram_en = issue & ~misalign;
      push_inst    = inflight_adel ? 32'h0 : inst_sram_rdata;
`else
      issue        = slot_ok;
      inst_sram_en = issue;
      push_inst    = inst_sram_rdata;
`endif
      inst_sram_addr = fpc;
   end

   // Fetch PC advance/redirect and tracking of the outstanding read
   always_ff @(posedge clk or negedge resetn) begin
      // NOTE: state registers use non-blocking assignments. Every flop then updates from pre-edge values.
      if (!resetn) begin
         fpc         <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= 32'h0;
      end else if (redirect_valid) begin
         fpc      <= redirect_pc;
         inflight <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) inflight_pc <= fpc;
         if (inst_sram_en) fpc <= fpc + 32'd4;
      end
   end

   // Buffer storage, pointers and occupancy count
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         // NOTE: the buffer is only a few entries, so it is cleared on reset. The head payload then reads zero.
         for (int i = 0; i < BUF_DEPTH; i++) begin
            fifo_pc[i]   <= 32'h0;
            fifo_inst[i] <= 32'h0;
         end
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (redirect_valid) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            fifo_pc[wr_ptr]   <= inflight_pc;
            fifo_inst[wr_ptr] <= push_inst;
            wr_ptr            <= ptr_inc(wr_ptr);
         end
         if (deq) rd_ptr <= ptr_inc(rd_ptr);
         if (push && !deq)      count <= count + CNT_W'(1);
         else if (!push && deq) count <= count - CNT_W'(1);
      end
   end

`ifdef IF_ADEL_CHECK_EN
   // Address-error tracking: the flag travels with its entry, and fetch halts until the next redirect
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         halted        <= 1'b0;
         inflight_adel <= 1'b0;
         for (int i = 0; i < BUF_DEPTH; i++) fifo_adel[i] <= 1'b0;
      end else if (redirect_valid) begin
         halted        <= 1'b0;
         inflight_adel <= 1'b0;
      end else begin
         if (issue) begin
            inflight_adel <= misalign;
            if (misalign) halted <= 1'b1;
         end
         if (push) fifo_adel[wr_ptr] <= inflight_adel;
      end
   end
`endif

   // Buffer head presented to ID
   always_comb begin
      if_to_id_valid = (count != '0);
      if_to_id_pc    = fifo_pc[rd_ptr];
      if_to_id_inst  = fifo_inst[rd_ptr];
`ifdef IF_ADEL_CHECK_EN
      if_to_id_adel  = fifo_adel[rd_ptr];
`endif
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Testbench for if_fetch_stage. It applies directed per-cycle vectors and a
// few hand-written multi-cycle sequences. Stimulus includes reset, streaming,
// stalls and redirects, and an address error when IF_ADEL_CHECK_EN is defined.
`timescale 1ns/1ps

module tb_if_fetch_stage;

   localparam logic [31:0] B = 32'hbfc00000;

   logic        clk;
   logic        resetn;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_sram_en;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_rdata;
   logic        id_allowin;
   logic        if_to_id_valid;
   logic [31:0] if_to_id_pc;
   logic [31:0] if_to_id_inst;
`ifdef IF_ADEL_CHECK_EN
   logic        if_to_id_adel;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   if_fetch_stage #(.RESET_PC(B), .BUF_DEPTH(2)) dut (
      .clk             (clk),
      .resetn          (resetn),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .inst_sram_en    (inst_sram_en),
      .inst_sram_addr  (inst_sram_addr),
      .inst_sram_rdata (inst_sram_rdata),
      .id_allowin      (id_allowin),
      .if_to_id_valid  (if_to_id_valid),
      .if_to_id_pc     (if_to_id_pc),
      .if_to_id_inst   (if_to_id_inst)
`ifdef IF_ADEL_CHECK_EN
      ,
      .if_to_id_adel   (if_to_id_adel)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory contents as a function of the address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5a5aa5a5;
   endfunction

   // SRAM model with one-cycle latency. A request seen in cycle k is returned
   // during cycle k+1. Cycles with no request return a junk marker.
   logic        prev_en   = 1'b0;
   logic [31:0] prev_addr = 32'h0;
   initial inst_sram_rdata = 32'hdeadbeef;
   always @(negedge clk) begin
      inst_sram_rdata = prev_en ? mem_word(prev_addr) : 32'hdeadbeef;
      prev_en         = inst_sram_en;
      prev_addr       = inst_sram_addr;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Drive one cycle's inputs just after the rising edge, then wait for the falling edge
   task automatic cycle(input logic rst_v, input logic al, input logic rv, input logic [31:0] rpc);
      @(posedge clk);
      #1;
      resetn         = rst_v;
      id_allowin     = al;
      redirect_valid = rv;
      redirect_pc    = rpc;
      @(negedge clk);
   endtask

   typedef struct {
      logic        al;
      logic        rv;
      logic [31:0] rpc;
      logic        en;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs [NV];

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      resetn         = 1'b0;
      id_allowin     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;

      //            al rv rpc      en addr      valid pc
      vecs[0]  = '{1, 0, 32'h0,   1, B+32'h000, 0, 32'h0};     // first issue at RESET_PC
      vecs[1]  = '{1, 0, 32'h0,   1, B+32'h004, 0, 32'h0};
      vecs[2]  = '{1, 0, 32'h0,   1, B+32'h008, 1, B+32'h000}; // valid two cycles after issue
      vecs[3]  = '{1, 0, 32'h0,   1, B+32'h00c, 1, B+32'h004};
      vecs[4]  = '{1, 0, 32'h0,   1, B+32'h010, 1, B+32'h008};
      vecs[5]  = '{0, 0, 32'h0,   0, B+32'h014, 1, B+32'h00c}; // stall: issue stops at 2 outstanding
      vecs[6]  = '{0, 0, 32'h0,   0, B+32'h014, 1, B+32'h00c};
      vecs[7]  = '{0, 0, 32'h0,   0, B+32'h014, 1, B+32'h00c};
      vecs[8]  = '{0, 0, 32'h0,   0, B+32'h014, 1, B+32'h00c};
      vecs[9]  = '{0, 0, 32'h0,   0, B+32'h014, 1, B+32'h00c};
      vecs[10] = '{1, 0, 32'h0,   1, B+32'h014, 1, B+32'h00c}; // resume in order
      vecs[11] = '{1, 0, 32'h0,   1, B+32'h018, 1, B+32'h010};
      vecs[12] = '{0, 1, B+32'h100, 0, B+32'h01c, 1, B+32'h014}; // redirect: 1 buffered + 1 in flight
      vecs[13] = '{1, 0, 32'h0,   1, B+32'h100, 0, 32'h0};
      vecs[14] = '{1, 0, 32'h0,   1, B+32'h104, 0, 32'h0};     // stale 018 return must not appear
      vecs[15] = '{1, 0, 32'h0,   1, B+32'h108, 1, B+32'h100};
      vecs[16] = '{1, 1, B+32'h200, 0, B+32'h10c, 1, B+32'h104}; // redirect with deq-eligible head
      vecs[17] = '{1, 0, 32'h0,   1, B+32'h200, 0, 32'h0};
      vecs[18] = '{1, 0, 32'h0,   1, B+32'h204, 0, 32'h0};
      vecs[19] = '{1, 0, 32'h0,   1, B+32'h208, 1, B+32'h200};

      // Outputs while reset is held
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst valid", {31'b0, if_to_id_valid}, 32'h0);
      check("rst en",    {31'b0, inst_sram_en},   32'h0);
      check("rst addr",  inst_sram_addr,          B);
      check("rst pc",    if_to_id_pc,             32'h0);
      check("rst inst",  if_to_id_inst,           32'h0);

      // Table-driven vectors, starting with the cycle in which reset is released
      for (int i = 0; i < NV; i++) begin
         cycle(1'b1, vecs[i].al, vecs[i].rv, vecs[i].rpc);
         check($sformatf("v%0d en", i),    {31'b0, inst_sram_en},   {31'b0, vecs[i].en});
         check($sformatf("v%0d addr", i),  inst_sram_addr,          vecs[i].addr);
         check($sformatf("v%0d valid", i), {31'b0, if_to_id_valid}, {31'b0, vecs[i].valid});
         if (vecs[i].valid) begin
            check($sformatf("v%0d pc", i),   if_to_id_pc,   vecs[i].pc);
            check($sformatf("v%0d inst", i), if_to_id_inst, mem_word(vecs[i].pc));
         end
      end

      // Reset pulse in mid-stream: outputs must go idle immediately
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      @(posedge clk);
      #1 resetn = 1'b0;
      #1;
      check("mrst en",    {31'b0, inst_sram_en},   32'h0);
      check("mrst valid", {31'b0, if_to_id_valid}, 32'h0);
      check("mrst addr",  inst_sram_addr,          B);
      check("mrst pc",    if_to_id_pc,             32'h0);
      @(negedge clk);
      check("mrst valid hold", {31'b0, if_to_id_valid}, 32'h0);

      // Restart from RESET_PC with the same timing as the first run
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      check("rs0 en",    {31'b0, inst_sram_en},   32'h1);
      check("rs0 addr",  inst_sram_addr,          B);
      check("rs0 valid", {31'b0, if_to_id_valid}, 32'h0);
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      check("rs1 addr",  inst_sram_addr,          B + 32'h4);
      check("rs1 valid", {31'b0, if_to_id_valid}, 32'h0);
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      check("rs2 valid", {31'b0, if_to_id_valid}, 32'h1);
      check("rs2 pc",    if_to_id_pc,             B);
      check("rs2 inst",  if_to_id_inst,           mem_word(B));
      check("rs2 addr",  inst_sram_addr,          B + 32'h8);
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      check("rs3 pc",    if_to_id_pc,             B + 32'h4);
      check("rs3 inst",  if_to_id_inst,           mem_word(B + 32'h4));

`ifdef IF_ADEL_CHECK_EN
      // Misaligned redirect: an error entry is produced and no SRAM read occurs until the next redirect
      cycle(1'b1, 1'b0, 1'b1, B + 32'h102);
      check("ad0 en", {31'b0, inst_sram_en}, 32'h0);
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      check("ad1 en",   {31'b0, inst_sram_en}, 32'h0);
      check("ad1 addr", inst_sram_addr,        B + 32'h102);
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      check("ad2 en",    {31'b0, inst_sram_en},   32'h0);
      check("ad2 valid", {31'b0, if_to_id_valid}, 32'h0);
      cycle(1'b1, 1'b0, 1'b0, 32'h0);
      check("ad3 valid", {31'b0, if_to_id_valid}, 32'h1);
      check("ad3 pc",    if_to_id_pc,             B + 32'h102);
      check("ad3 inst",  if_to_id_inst,           32'h0);
      check("ad3 adel",  {31'b0, if_to_id_adel},  32'h1);
      check("ad3 en",    {31'b0, inst_sram_en},   32'h0);
      cycle(1'b1, 1'b1, 1'b1, B + 32'h200);
      check("ad4 en", {31'b0, inst_sram_en}, 32'h0);
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      check("ad5 en",   {31'b0, inst_sram_en}, 32'h1);
      check("ad5 addr", inst_sram_addr,        B + 32'h200);
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      check("ad6 addr", inst_sram_addr, B + 32'h204);
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      check("ad7 valid", {31'b0, if_to_id_valid}, 32'h1);
      check("ad7 pc",    if_to_id_pc,             B + 32'h200);
      check("ad7 inst",  if_to_id_inst,           mem_word(B + 32'h200));
      check("ad7 adel",  {31'b0, if_to_id_adel},  32'h0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
